// File: rtl/chan_scan_mux.sv
// Channel multiplexer with manual select and auto-scan (dwell / hold) modes.
// Optional CHAN_SCAN_MUX_MASK_EN adds en_mask so scanning skips disabled channels.
module chan_scan_mux #(
    parameter int            N_CH    = 4,
    parameter int            W       = 2,
    parameter int            DWELL_W = 8,
    parameter logic [W-1:0]  DEFAULT = '0,
    localparam int           SEL_W   = $clog2(N_CH)
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef CHAN_SCAN_MUX_MASK_EN
    input  logic [N_CH-1:0]      en_mask,
`endif
    input  logic [N_CH*W-1:0]    din,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 mode,
    input  logic                 hold,
    input  logic [DWELL_W-1:0]   dwell,
    output logic [W-1:0]         dout,
    output logic [SEL_W-1:0]     cur_ch,
    output logic                 chg
);

    typedef enum logic [1:0] {
        MANUAL = 2'd0,
        SCAN   = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t             state_reg, state_next;
    logic [DWELL_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0]   cur_ch_reg, cur_ch_next;
    logic [W-1:0]       dout_reg, dout_next;
    logic               chg_reg;
    logic [SEL_W-1:0]   adv_ch;
    logic [W-1:0]       ch [N_CH];

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
        assign ch[gi] = din[gi*W +: W];
    end

    // Next channel in wrap order, taken when the dwell count terminates.
`ifdef CHAN_SCAN_MUX_MASK_EN
    always_comb begin
        logic             found;
        logic [SEL_W-1:0] idx;
        adv_ch = cur_ch_reg;
        found  = 1'b0;
        for (int k = 1; k <= N_CH; k++) begin
            idx = SEL_W'((32'(cur_ch_reg) + 32'(k)) % 32'(N_CH));
            if (!found && en_mask[idx]) begin
                adv_ch = idx;
                found  = 1'b1;
            end
        end
    end
`else
    always_comb begin
        adv_ch = (cur_ch_reg == SEL_W'(N_CH - 1)) ? '0 : cur_ch_reg + SEL_W'(1);
    end
`endif

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        cur_ch_next = cur_ch_reg;
        case (state_reg)
            MANUAL: begin
                cnt_next = '0;
                if (mode) begin
                    state_next  = SCAN;
                    cur_ch_next = (32'(cur_ch_reg) < 32'(N_CH)) ? cur_ch_reg : '0;
                end else begin
                    cur_ch_next = sel;
                end
            end
            SCAN: begin
                if (!mode) begin
                    state_next  = MANUAL;
                    cur_ch_next = sel;
                    cnt_next    = '0;
                end else if (hold) begin
                    state_next = HOLD;
                end else if (cnt_reg == dwell) begin
                    cnt_next    = '0;
                    cur_ch_next = adv_ch;
                end else begin
                    cnt_next = cnt_reg + DWELL_W'(1);
                end
            end
            HOLD: begin
                if (!mode) begin
                    state_next  = MANUAL;
                    cur_ch_next = sel;
                    cnt_next    = '0;
                end else if (!hold) begin
                    state_next = SCAN;
                end
            end
            default: begin
                state_next  = MANUAL;
                cnt_next    = '0;
                cur_ch_next = '0;
            end
        endcase
    end

    // Data follows the index being registered so dout and cur_ch stay aligned.
    always_comb begin
        dout_next = DEFAULT;
        if (32'(cur_ch_next) < 32'(N_CH)) begin
            dout_next = ch[cur_ch_next];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= MANUAL;
            cnt_reg    <= '0;
            cur_ch_reg <= '0;
            dout_reg   <= '0;
            chg_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            cur_ch_reg <= cur_ch_next;
            dout_reg   <= dout_next;
            chg_reg    <= (cur_ch_next != cur_ch_reg);
        end
    end

    assign dout   = dout_reg;
    assign cur_ch = cur_ch_reg;
    assign chg    = chg_reg;

endmodule

// File: tb/tb_chan_scan_mux.sv
// Directed bench for chan_scan_mux: default 4-channel instance plus a
// 3-channel instance exercising the out-of-range DEFAULT value.
module tb_chan_scan_mux;

    logic        clk;
    logic        rst;
    logic [7:0]  din;
    logic [1:0]  sel;
    logic        mode, hold;
    logic [7:0]  dwell;
    logic [1:0]  dout;
    logic [1:0]  cur_ch;
    logic        chg;

    logic [11:0] din1;
    logic [1:0]  sel1;
    logic        mode1;
    logic [3:0]  dout1;
    logic [1:0]  cur_ch1;
    logic        chg1;

`ifdef CHAN_SCAN_MUX_MASK_EN
    logic [3:0]  en_mask;
    logic [2:0]  en_mask1;
`endif

    int errors = 0;
    int checks = 0;

    chan_scan_mux u0 (
        .clk    (clk),
        .rst    (rst),
`ifdef CHAN_SCAN_MUX_MASK_EN
        .en_mask(en_mask),
`endif
        .din    (din),
        .sel    (sel),
        .mode   (mode),
        .hold   (hold),
        .dwell  (dwell),
        .dout   (dout),
        .cur_ch (cur_ch),
        .chg    (chg)
    );

    chan_scan_mux #(.N_CH(3), .W(4), .DWELL_W(8), .DEFAULT(4'hF)) u1 (
        .clk    (clk),
        .rst    (rst),
`ifdef CHAN_SCAN_MUX_MASK_EN
        .en_mask(en_mask1),
`endif
        .din    (din1),
        .sel    (sel1),
        .mode   (mode1),
        .hold   (1'b0),
        .dwell  (8'd0),
        .dout   (dout1),
        .cur_ch (cur_ch1),
        .chg    (chg1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        din   = 8'b11_10_01_00;
        sel   = 2'd0;
        mode  = 1'b0;
        hold  = 1'b0;
        dwell = 8'd0;
        din1  = {4'h9, 4'h5, 4'h3};
        sel1  = 2'd0;
        mode1 = 1'b0;
`ifdef CHAN_SCAN_MUX_MASK_EN
        en_mask  = 4'b1111;
        en_mask1 = 3'b111;
`endif
        #2;
        chk("rst_cur", 32'(cur_ch), 0);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_chg", 32'(chg), 0);
        edge1();
        edge1();
        rst = 1'b0;
        sel = 2'd2;

        // Manual select of channel 2
        edge1();
        chk("man_cur", 32'(cur_ch), 2);
        chk("man_dout", 32'(dout), 2);
        chk("man_chg", 32'(chg), 1);
        edge1();
        chk("man_chg_clr", 32'(chg), 0);
        $display("manual sel=2 cur_ch=%0d dout=%0d", cur_ch, dout);

        // Scan with dwell=2 starting from channel 3
        sel = 2'd3;
        edge1();
        chk("man3_cur", 32'(cur_ch), 3);
        mode  = 1'b1;
        dwell = 8'd2;
        edge1();
        chk("scan_entry_cur", 32'(cur_ch), 3);
        chk("scan_entry_chg", 32'(chg), 0);
        for (int i = 1; i <= 15; i++) begin
            edge1();
            chk("scan_d2_cur", 32'(cur_ch), (3 + i / 3) % 4);
            chk("scan_d2_dout", 32'(dout), (3 + i / 3) % 4);
            chk("scan_d2_chg", 32'(chg), (i % 3 == 0) ? 1 : 0);
            $display("scan dwell=2 step=%0d cur_ch=%0d chg=%0d", i, cur_ch, chg);
        end

        // dwell=0 advances every cycle; hold on cycle 5 freezes it
        dwell = 8'd0;
        for (int i = 1; i <= 4; i++) begin
            edge1();
            chk("scan_d0_cur", 32'(cur_ch), i % 4);
        end
        hold = 1'b1;
        edge1();
        chk("hold_cur", 32'(cur_ch), 0);
        chk("hold_chg", 32'(chg), 0);
        edge1();
        chk("hold_cur2", 32'(cur_ch), 0);
        din = 8'b11_10_01_11;
        edge1();
        chk("hold_din_dout", 32'(dout), 3);
        chk("hold_cur3", 32'(cur_ch), 0);
        $display("hold cur_ch=%0d dout=%0d", cur_ch, dout);
        din  = 8'b11_10_01_00;
        hold = 1'b0;
        edge1();
        edge1();
        chk("resume_cur", 32'(cur_ch), 1);
        chk("resume_chg", 32'(chg), 1);

        // Long dwell, then asynchronous reset at cnt=5
        dwell = 8'd10;
        for (int i = 1; i <= 5; i++) begin
            edge1();
            chk("dwell10_cur", 32'(cur_ch), 1);
        end
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_cur", 32'(cur_ch), 0);
        chk("async_rst_dout", 32'(dout), 0);
        chk("async_rst_chg", 32'(chg), 0);
        $display("async reset cur_ch=%0d dout=%0d", cur_ch, dout);
        #2;
        rst  = 1'b0;
        mode = 1'b0;
        sel  = 2'd2;
        edge1();
        chk("post_rst_cur", 32'(cur_ch), 2);
        chk("post_rst_dout", 32'(dout), 2);

        // mode=0 overrides hold
        mode = 1'b1;
        edge1();
        chk("prio_scan_cur", 32'(cur_ch), 2);
        hold = 1'b1;
        edge1();
        mode = 1'b0;
        sel  = 2'd3;
        edge1();
        chk("prio_mode_cur", 32'(cur_ch), 3);
        chk("prio_mode_dout", 32'(dout), 3);
        hold = 1'b0;

        // Out-of-range manual select on the 3-channel instance
        sel1 = 2'd3;
        edge1();
        chk("oor_cur", 32'(cur_ch1), 3);
        chk("oor_dout", 32'(dout1), 32'hF);
        mode1 = 1'b1;
        edge1();
        chk("oor_scan_cur", 32'(cur_ch1), 0);
        chk("oor_scan_dout", 32'(dout1), 3);
        edge1();
        chk("n3_cur1", 32'(cur_ch1), 1);
        chk("n3_dout1", 32'(dout1), 5);
        edge1();
        chk("n3_cur2", 32'(cur_ch1), 2);
        chk("n3_dout2", 32'(dout1), 9);
        edge1();
        chk("n3_wrap", 32'(cur_ch1), 0);
        $display("3ch scan wrap cur_ch=%0d dout=%0h", cur_ch1, dout1);

`ifdef CHAN_SCAN_MUX_MASK_EN
        en_mask = 4'b1010;
        sel     = 2'd0;
        dwell   = 8'd0;
        edge1();
        chk("mask_man_cur", 32'(cur_ch), 0);
        mode = 1'b1;
        edge1();
        for (int i = 0; i < 4; i++) begin
            edge1();
            chk("mask_seq", 32'(cur_ch), (i % 2 == 0) ? 1 : 3);
            $display("mask scan step=%0d cur_ch=%0d", i, cur_ch);
        end
        en_mask = 4'b0000;
        for (int i = 0; i < 3; i++) begin
            edge1();
            chk("mask_zero_hold", 32'(cur_ch), 3);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
